pulse_width_meter: RTL and testbench
====================================

PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bit width of the width and period counters and outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 16'hFFFF, giving the number of cycles at one level after which the measurement is abandoned.
REQ-003 The block SHALL have port INPUT_CLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port EN, input, 1 bit: measurement enable.
REQ-006 The block SHALL have port SIG_IN, input, 1 bit: the asynchronous square wave under measurement (oscillator or divided clock).
REQ-007 The block SHALL have port HIGH_WIDTH, output, WIDTH bits: the last complete high-phase length, in INPUT_CLK cycles.
REQ-008 The block SHALL have port LOW_WIDTH, output, WIDTH bits: the last complete low-phase length, in INPUT_CLK cycles.
REQ-009 The block SHALL have port PERIOD, output, WIDTH bits: HIGH_WIDTH+LOW_WIDTH of the same period.
REQ-010 The block SHALL have port VALID, output, 1 bit: a one-cycle pulse when new HIGH_WIDTH/LOW_WIDTH/PERIOD are loaded.
REQ-011 The block SHALL have port STALLED, output, 1 bit: a sticky flag set when TIMEOUT elapses without an edge.

Function
REQ-012 SIG_IN SHALL pass through a 2-flop synchronizer; a third register SHALL hold the previous synchronized value for edge detection (rise = sync & ~prev, fall = ~sync & prev).
REQ-013 The FSM SHALL have three states: IDLE, MEAS_HIGH and MEAS_LOW.
REQ-014 In IDLE, on rise the FSM SHALL go to MEAS_HIGH with high_cnt=1; fall and steady levels are ignored.
REQ-015 In MEAS_HIGH, on fall the FSM SHALL go to MEAS_LOW with low_cnt=1; otherwise high_cnt increments.
REQ-016 In MEAS_LOW, on rise the block SHALL load HIGH_WIDTH=high_cnt, LOW_WIDTH=low_cnt and PERIOD=high_cnt+low_cnt, assert VALID for exactly one cycle, and return to MEAS_HIGH with high_cnt=1; otherwise low_cnt increments.
REQ-017 A width SHALL equal the number of cycles the synchronized signal held that level; outputs SHALL be registered and become visible the cycle after the closing rise is detected.
REQ-018 The first period after IDLE SHALL be measured fully; no VALID SHALL be issued before one complete high+low phase.
REQ-019 Counters and PERIOD SHALL saturate at 2^WIDTH-1 and never wrap.
REQ-020 If high_cnt or low_cnt reaches TIMEOUT, the block SHALL set STALLED, go to IDLE, issue no VALID and leave outputs unchanged.
REQ-021 STALLED SHALL clear on the next detected rise.
REQ-022 EN low SHALL force IDLE and clear the counters; outputs SHALL hold and VALID SHALL stay 0.
REQ-023 EN low SHALL take priority over a simultaneous edge.
REQ-024 An edge coinciding with the TIMEOUT cycle SHALL be treated as an edge, not a timeout.
REQ-025 A glitch shorter than one INPUT_CLK cycle MAY be missed; a level held at least 2 cycles SHALL be measured exactly.

Reset
REQ-026 RST low SHALL asynchronously clear the synchronizer, previous-value register, counters, HIGH_WIDTH, LOW_WIDTH, PERIOD, VALID and STALLED to 0, and set the state to IDLE.
REQ-027 Reset mid-measurement SHALL discard the partial period; after release, measurement SHALL restart from IDLE.

Structure
REQ-028 The state enum (IDLE, MEAS_HIGH, MEAS_LOW) and the default WIDTH/TIMEOUT constants SHALL live in the shared package pt_osc_pkg.
REQ-029 The synchronizer and edge detector SHALL be one sub-module, sync_edge_detect, with outputs level, rise and fall.

Verification
REQ-030 Scenario: SIG_IN driven by CLOCK_N_DIVIDER with DIVIDER=8 from the same INPUT_CLK -> first VALID after two rises; HIGH_WIDTH=4, LOW_WIDTH=4, PERIOD=8 on every later VALID, one VALID per 8 cycles.
REQ-031 Scenario: SIG_IN high 3 cycles, low 7 cycles, repeated -> HIGH_WIDTH=3, LOW_WIDTH=7, PERIOD=10; DIVIDER=2 source -> 1/1/2.
REQ-032 Scenario: TIMEOUT=20, SIG_IN stuck high after one rise -> STALLED=1 20 cycles after the rise, no VALID; resume a 4/4 square wave -> STALLED=0 at the first rise, then VALID with 4/4/8.
REQ-033 Scenario: WIDTH=4, TIMEOUT=4'hF, low phase of 20 cycles -> STALLED, no wrap to small values; low phase of 14 cycles -> LOW_WIDTH=14.
REQ-034 Scenario: RST pulsed low mid MEAS_LOW -> all outputs 0 immediately (asynchronous); next VALID only after a complete new period.
REQ-035 Scenario: EN dropped for 5 cycles during a 4/4 wave -> outputs hold, VALID=0; after EN rises, the first VALID follows one full period with 4/4/8.

Source files
------------

// File: rtl/pt_osc_pkg.sv
// Shared types and default sizing for the oscillator / pulse-width measurement blocks.
package pt_osc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } meas_state_e;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_TIMEOUT = 32'h0000_FFFF;

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose: 2-flop synchronizer for an async level plus a previous-value register for edge detection.
// Latency: level/rise/fall reflect SIG_IN two INPUT_CLK edges after it is first sampled.
// Backpressure: none; free-running, outputs are valid every cycle.
module sync_edge_detect (
  input  logic INPUT_CLK,
  input  logic RST,
  input  logic SIG_IN,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  always_ff @(posedge INPUT_CLK or negedge RST) begin
    if (!RST) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= SIG_IN;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign level = sync_q2;
  assign rise  = sync_q2 & ~prev_q;
  assign fall  = ~sync_q2 & prev_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Purpose: measures high/low phase lengths and period of an async square wave in INPUT_CLK cycles.
// Latency: results and the VALID pulse appear one cycle after the closing rise is detected.
// Backpressure: none; VALID is a one-cycle strobe and results hold until the next full period.
module pulse_width_meter
  import pt_osc_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             INPUT_CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SIG_IN,
  output logic [WIDTH-1:0] HIGH_WIDTH,
  output logic [WIDTH-1:0] LOW_WIDTH,
  output logic [WIDTH-1:0] PERIOD,
  output logic             VALID,
  output logic             STALLED
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TO_LIM  = WIDTH'(TIMEOUT);

  meas_state_e      state_q;
  meas_state_e      state_nxt;
  logic [WIDTH-1:0] high_cnt_q;
  logic [WIDTH-1:0] low_cnt_q;
  logic [WIDTH:0]   period_sum;
  logic [WIDTH-1:0] period_sat;
  logic             sig_lvl;
  logic             rise;
  logic             fall;
  logic             hi_to;
  logic             lo_to;

  logic hi_load1, hi_inc, lo_load1, lo_inc, cnt_clr;
  logic meas_ld, stall_set, stall_clr;

  sync_edge_detect u_sync (
    .INPUT_CLK (INPUT_CLK),
    .RST       (RST),
    .SIG_IN    (SIG_IN),
    .level     (sig_lvl),
    .rise      (rise),
    .fall      (fall)
  );

  assign hi_to      = (high_cnt_q >= TO_LIM);
  assign lo_to      = (low_cnt_q >= TO_LIM);
  assign period_sum = {1'b0, high_cnt_q} + {1'b0, low_cnt_q};
  assign period_sat = period_sum[WIDTH] ? CNT_MAX : period_sum[WIDTH-1:0];

  always_ff @(posedge INPUT_CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  // An edge always wins over a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state_q;
    if (!EN) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (rise) state_nxt = MEAS_HIGH;
        MEAS_HIGH: if (fall) state_nxt = MEAS_LOW;
                   else if (hi_to) state_nxt = IDLE;
        MEAS_LOW:  if (rise) state_nxt = MEAS_HIGH;
                   else if (lo_to) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    hi_load1  = 1'b0;
    hi_inc    = 1'b0;
    lo_load1  = 1'b0;
    lo_inc    = 1'b0;
    cnt_clr   = 1'b0;
    meas_ld   = 1'b0;
    stall_set = 1'b0;
    stall_clr = 1'b0;
    if (!EN) begin
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            hi_load1  = 1'b1;
            stall_clr = 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            lo_load1 = 1'b1;
          end else if (hi_to) begin
            stall_set = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            hi_inc = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            meas_ld   = 1'b1;
            hi_load1  = 1'b1;
            stall_clr = 1'b1;
          end else if (lo_to) begin
            stall_set = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            lo_inc = 1'b1;
          end
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge INPUT_CLK or negedge RST) begin
    if (!RST) begin
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      HIGH_WIDTH <= '0;
      LOW_WIDTH  <= '0;
      PERIOD     <= '0;
      VALID      <= 1'b0;
      STALLED    <= 1'b0;
    end else begin
      if (cnt_clr) begin
        high_cnt_q <= '0;
        low_cnt_q  <= '0;
      end else begin
        if (hi_load1)    high_cnt_q <= CNT_ONE;
        else if (hi_inc) high_cnt_q <= (high_cnt_q == CNT_MAX) ? CNT_MAX : high_cnt_q + CNT_ONE;
        if (lo_load1)    low_cnt_q  <= CNT_ONE;
        else if (lo_inc) low_cnt_q  <= (low_cnt_q == CNT_MAX) ? CNT_MAX : low_cnt_q + CNT_ONE;
      end
      VALID <= meas_ld;
      if (meas_ld) begin
        HIGH_WIDTH <= high_cnt_q;
        LOW_WIDTH  <= low_cnt_q;
        PERIOD     <= period_sat;
      end
      if (stall_set)      STALLED <= 1'b1;
      else if (stall_clr) STALLED <= 1'b0;
    end
  end

  // While measuring, the synchronized level must match the phase unless the closing edge is present.
  a_high_level: assert property (@(posedge INPUT_CLK) disable iff (!RST)
    (state_q == MEAS_HIGH && !fall) |-> sig_lvl);
  a_low_level: assert property (@(posedge INPUT_CLK) disable iff (!RST)
    (state_q == MEAS_LOW && !rise) |-> !sig_lvl);

endmodule

// File: tb/tb_pulse_width_meter.sv
// Two meters (16-bit/TIMEOUT=20 and 4-bit/TIMEOUT=15) share one stimulus and are checked
// every cycle against an edge-timestamp model, plus literal expectations for the directed cases.
module tb_pulse_width_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, sig;
  logic [15:0] hw_a, lw_a, per_a;
  logic        vld_a, stl_a;
  logic [3:0]  hw_b, lw_b, per_b;
  logic        vld_b, stl_b;

  pulse_width_meter #(.WIDTH(16), .TIMEOUT(20)) dut_a (
    .INPUT_CLK(clk), .RST(rst_n), .EN(en), .SIG_IN(sig),
    .HIGH_WIDTH(hw_a), .LOW_WIDTH(lw_a), .PERIOD(per_a), .VALID(vld_a), .STALLED(stl_a));

  pulse_width_meter #(.WIDTH(4), .TIMEOUT(15)) dut_b (
    .INPUT_CLK(clk), .RST(rst_n), .EN(en), .SIG_IN(sig),
    .HIGH_WIDTH(hw_b), .LOW_WIDTH(lw_b), .PERIOD(per_b), .VALID(vld_b), .STALLED(stl_b));

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt_a  = 0;
  bit chk_on  = 0;

  // Model: remembers the cycle of the opening rise and of the fall; widths are timestamp differences.
  typedef struct {
    int rise_t; int fall_t; bit trk;
    int hw; int lw; int per; bit vld; bit stl;
  } mdl_t;
  mdl_t m [2];
  int   to_lim [2] = '{20, 15};
  int   sat    [2] = '{65535, 15};
  bit   s1, s2, pv, m_r, m_f;
  int   cyc = 0;

  function automatic int smin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < 2; i++) m[i] = '{-1, -1, 1'b0, 0, 0, 0, 1'b0, 1'b0};
    s1 = 0; s2 = 0; pv = 0;
  endfunction

  function automatic void mdl_step(input int i, input bit r, input bit f);
    int st;
    m[i].vld = 0;
    if (en !== 1'b1) begin
      m[i].trk = 0;
      return;
    end
    if (r) begin
      m[i].stl = 0;
      if (m[i].trk && m[i].fall_t >= 0) begin
        m[i].hw  = smin(m[i].fall_t - m[i].rise_t, sat[i]);
        m[i].lw  = smin(cyc - m[i].fall_t, sat[i]);
        m[i].per = smin(m[i].hw + m[i].lw, sat[i]);
        m[i].vld = 1;
      end
      m[i].trk = 1; m[i].rise_t = cyc; m[i].fall_t = -1;
    end else if (f) begin
      if (m[i].trk && m[i].fall_t < 0) m[i].fall_t = cyc;
    end else if (m[i].trk) begin
      st = (m[i].fall_t >= 0) ? m[i].fall_t : m[i].rise_t;
      if (cyc - st >= to_lim[i]) begin
        m[i].stl = 1;
        m[i].trk = 0;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (rst_n !== 1'b1) begin
      mdl_clear();
    end else begin
      m_r = s2 & ~pv;
      m_f = ~s2 & pv;
      for (int i = 0; i < 2; i++) mdl_step(i, m_r, m_f);
      pv = s2; s2 = s1; s1 = sig;
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (vld_a === 1'b1) vcnt_a++;
    check("A.HIGH_WIDTH", int'(hw_a),  m[0].hw);
    check("A.LOW_WIDTH",  int'(lw_a),  m[0].lw);
    check("A.PERIOD",     int'(per_a), m[0].per);
    check("A.VALID",      int'(vld_a), int'(m[0].vld));
    check("A.STALLED",    int'(stl_a), int'(m[0].stl));
    check("B.HIGH_WIDTH", int'(hw_b),  m[1].hw);
    check("B.LOW_WIDTH",  int'(lw_b),  m[1].lw);
    check("B.PERIOD",     int'(per_b), m[1].per);
    check("B.VALID",      int'(vld_b), int'(m[1].vld));
    check("B.STALLED",    int'(stl_b), int'(m[1].stl));
  endtask

  // From #1 after a rising edge: compare at the falling edge, then advance to #1 after the next rise.
  task automatic step();
    @(negedge clk);
    if (chk_on) compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input bit lv, input int n);
    sig = lv;
    repeat (n) step();
  endtask

  task automatic check_a(input string tag, input int h, input int l, input int p);
    check({tag, ".A.HIGH_WIDTH"}, int'(hw_a), h);
    check({tag, ".A.LOW_WIDTH"},  int'(lw_a), l);
    check({tag, ".A.PERIOD"},     int'(per_a), p);
  endtask

  int v0;
  int rlen;
  bit rlv;

  initial begin
    rst_n = 1'b0; en = 1'b0; sig = 1'b0;
    @(posedge clk); #1;
    repeat (3) step();
    check("reset.HIGH_WIDTH", int'(hw_a), 0);
    check("reset.PERIOD",     int'(per_a), 0);
    check("reset.VALID",      int'(vld_a), 0);
    check("reset.STALLED",    int'(stl_a), 0);
    check("reset.B.LOW_WIDTH", int'(lw_b), 0);
    chk_on = 1;
    rst_n = 1'b1; en = 1'b1;

    // divide-by-8 source: four VALIDs from five rises
    v0 = vcnt_a;
    phase(0, 4);
    repeat (4) begin phase(1, 4); phase(0, 4); end
    phase(1, 4);
    check("div8.valid_count", vcnt_a - v0, 4);
    check_a("div8", 4, 4, 8);

    // 3 high / 7 low, then divide-by-2
    phase(0, 7);
    repeat (3) begin phase(1, 3); phase(0, 7); end
    phase(1, 3);
    check_a("h3l7", 3, 7, 10);
    check("h3l7.B.PERIOD", int'(per_b), 10);
    repeat (6) begin phase(1, 1); phase(0, 1); end
    phase(1, 1);
    phase(0, 2);
    check_a("div2", 1, 1, 2);

    // stuck high after a single rise from IDLE
    en = 1'b0; step(); step(); en = 1'b1;
    phase(0, 6);
    v0 = vcnt_a;
    phase(1, 30);
    check("stuck.A.STALLED", int'(stl_a), 1);
    check("stuck.B.STALLED", int'(stl_b), 1);
    check("stuck.valid_count", vcnt_a - v0, 0);
    phase(0, 4); phase(1, 4);
    check("resume.A.STALLED", int'(stl_a), 0);
    phase(0, 4); phase(1, 4);
    check_a("resume", 4, 4, 8);

    // narrow counter: 20-cycle low stalls B, 14-cycle low measures exactly, PERIOD saturates
    phase(0, 4); phase(1, 4); phase(0, 20);
    check("narrow.B.STALLED", int'(stl_b), 1);
    check("narrow.B.LOW_WIDTH_held", int'(lw_b), 4);
    phase(1, 4); phase(0, 14); phase(1, 4);
    check("narrow.B.HIGH_WIDTH", int'(hw_b), 4);
    check("narrow.B.LOW_WIDTH", int'(lw_b), 14);
    check("narrow.B.PERIOD", int'(per_b), 15);
    check("narrow.A.LOW_WIDTH", int'(lw_a), 14);

    // asynchronous reset in the middle of a low phase
    phase(0, 4); phase(1, 4); phase(0, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst.A.HIGH_WIDTH", int'(hw_a), 0);
    check("arst.A.LOW_WIDTH",  int'(lw_a), 0);
    check("arst.A.PERIOD",     int'(per_a), 0);
    check("arst.B.HIGH_WIDTH", int'(hw_b), 0);
    step(); step();
    rst_n = 1'b1;
    v0 = vcnt_a;
    phase(0, 2);
    phase(1, 4); phase(0, 4); phase(1, 4); phase(0, 4); phase(1, 4);
    check("arst.valid_count", vcnt_a - v0, 2);
    check_a("arst", 4, 4, 8);

    // enable dropped for five cycles
    phase(0, 4); phase(1, 4);
    v0 = vcnt_a;
    en = 1'b0;
    phase(0, 4); phase(1, 1);
    check("en_low.valid_count", vcnt_a - v0, 0);
    check_a("en_low", 4, 4, 8);
    en = 1'b1;
    phase(1, 3); phase(0, 4); phase(1, 4); phase(0, 4); phase(1, 4);
    check_a("en_back", 4, 4, 8);

    // randomized phases with occasional enable drops and resets
    rlv = 1'b0;
    for (int k = 0; k < 300; k++) begin
      rlv  = ~rlv;
      rlen = $urandom_range(1, 30);
      en   = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 79) == 0) begin
        @(posedge clk); #3;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      phase(rlv, rlen);
    end
    en = 1'b1;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
